// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the shift-add MUL write-back unit.
package mul_pkg;

    localparam int MUL_DW      = 8;
    localparam int MUL_AW      = 3;
    localparam int CALC_CYCLES = 8;
    localparam int CNT_W       = $clog2(CALC_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add datapath: latched multiplicand/multiplier, 2*DW accumulator and step counter.
// i_clear loads fresh operands; each i_step folds one multiplier bit into the accumulator.
module mul_shift_add
    import mul_pkg::*;
#(
    parameter int DW = MUL_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [DW-1:0]     i_mcand,
    input  logic [DW-1:0]     i_mplier,
    output logic [2*DW-1:0]   o_acc,
    output logic [CNT_W-1:0]  o_count
);

    logic [DW-1:0]    r_mcand;
    logic [DW-1:0]    r_mplier;
    logic [2*DW-1:0]  r_acc;
    logic [CNT_W-1:0] r_count;
    logic [2*DW-1:0]  w_addend;

    // Partial product for the current bit position, widened before the shift so no bits drop.
    assign w_addend = {{DW{1'b0}}, r_mcand} << r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + w_addend;
            end
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
        end
    end

    assign o_acc   = r_acc;
    assign o_count = r_count;

endmodule

// File: rtl/mul_wb_unit.sv
// Sequential 8x8 MUL unit: IDLE -> CALC (8 steps) -> WB_LO [-> WB_HI] -> IDLE, writing into the reg file.
// Define MUL_HI_WRITE_EN to also write the product high byte to register (dest+1) mod 2**AW.
module mul_wb_unit
    import mul_pkg::*;
#(
    parameter int DW = MUL_DW,
    parameter int AW = MUL_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] opA,
    input  logic [DW-1:0] opB,
    input  logic [AW-1:0] dest,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          write_en,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] data_in
);

    mul_state_t       r_state;
    logic [AW-1:0]    r_dest;
    logic             r_write_en;
    logic [AW-1:0]    r_waddr;
    logic [DW-1:0]    r_data_in;
    logic             r_done;
    logic             r_ovf;

    logic             w_clear;
    logic             w_step;
    logic [2*DW-1:0]  w_acc;
    logic [CNT_W-1:0] w_count;

    // Operands are captured only on an accepted start, so later input changes are harmless.
    assign w_clear = (r_state == IDLE) && start;
    assign w_step  = (r_state == CALC);

    mul_shift_add #(
        .DW (DW)
    ) u_shift_add (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_mcand  (opA),
        .i_mplier (opB),
        .o_acc    (w_acc),
        .o_count  (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dest     <= '0;
            r_write_en <= 1'b0;
            r_waddr    <= '0;
            r_data_in  <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dest  <= dest;
                        r_ovf   <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    // The final step lands on this same edge, so the count reaches CALC_CYCLES in WB_LO.
                    if (w_count == CNT_W'(CALC_CYCLES - 1)) begin
                        r_state <= WB_LO;
                    end
                end
                WB_LO: begin
                    r_write_en <= 1'b1;
                    r_waddr    <= r_dest;
                    r_data_in  <= w_acc[DW-1:0];
                    r_ovf      <= |w_acc[2*DW-1:DW];
`ifdef MUL_HI_WRITE_EN
                    r_state    <= WB_HI;
`else
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
`endif
                end
                WB_HI: begin
`ifdef MUL_HI_WRITE_EN
                    r_write_en <= 1'b1;
                    r_waddr    <= r_dest + AW'(1);
                    r_data_in  <= w_acc[2*DW-1:DW];
                    r_done     <= 1'b1;
`endif
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign ovf      = r_ovf;
    assign write_en = r_write_en;
    assign waddr    = r_waddr;
    assign data_in  = r_data_in;

endmodule

// File: tb/tb_mul_wb_unit.sv
// Scoreboard bench for mul_wb_unit: a timeline model predicts each register-file write and the
// busy/ovf levels; a negedge monitor compares every cycle. Honours MUL_HI_WRITE_EN.
module tb_mul_wb_unit;

`ifdef MUL_HI_WRITE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif
    localparam int WB_DELAY  = 9;
    localparam int OP_PERIOD = HI_EN ? 11 : 10;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] opA;
    logic [7:0] opB;
    logic [2:0] dest;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       write_en;
    logic [2:0] waddr;
    logic [7:0] data_in;

    mul_wb_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opA      (opA),
        .opB      (opB),
        .dest     (dest),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .write_en (write_en),
        .waddr    (waddr),
        .data_in  (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [2:0] addr;
        logic [7:0] data;
        logic       done;
    } wr_t;

    wr_t        exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         edge_cnt  = 0;
    int         free_edge = 0;
    int         ovf_edge  = -1;
    logic       ovf_val   = 1'b0;
    logic       ovf_exp   = 1'b0;
    logic [2:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [15:0] prod;
    logic [2:0]  hi_addr;
    bit          exp_we;
    wr_t         head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Model: a request is taken when start is seen with the unit free; the low-byte write
    // appears WB_DELAY edges later and the unit is free again OP_PERIOD edges after acceptance.
    always @(posedge clk) begin
        edge_cnt++;
        if (edge_cnt == ovf_edge) ovf_exp = ovf_val;
        if (!reset && start && edge_cnt >= free_edge) begin
            prod = 16'(opA) * 16'(opB);
            exp_q.push_back('{edge_cnt + WB_DELAY, dest, prod[7:0], !HI_EN});
            if (HI_EN) begin
                hi_addr = dest + 3'd1;
                exp_q.push_back('{edge_cnt + WB_DELAY + 1, hi_addr, prod[15:8], 1'b1});
            end
            ovf_exp   = 1'b0;
            ovf_edge  = edge_cnt + WB_DELAY;
            ovf_val   = (prod > 16'd255);
            free_edge = edge_cnt + OP_PERIOD;
        end
    end

    always @(negedge clk) begin
        exp_we = (exp_q.size() > 0) && (exp_q[0].at_edge == edge_cnt);
        check("write_en", write_en, exp_we);
        check("busy", busy, edge_cnt <= free_edge - 2);
        check("ovf", ovf, ovf_exp);
        if (exp_we) begin
            head      = exp_q.pop_front();
            last_addr = head.addr;
            last_data = head.data;
            check("done", done, head.done);
        end else begin
            check("done_idle", done, 1'b0);
        end
        check("waddr", waddr, last_addr);
        check("data_in", data_in, last_data);
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        @(negedge clk);
        start = 1'b1;
        opA   = a;
        opB   = b;
        dest  = d;
        @(negedge clk);
        start = 1'b0;
        opA   = 8'($urandom);
        opB   = 8'($urandom);
        dest  = 3'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_en"}, write_en, 1'b0);
        check({tag, "_waddr"}, waddr, 3'd0);
        check({tag, "_data_in"}, data_in, 8'd0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ovf"}, ovf, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opA   = '0;
        opB   = '0;
        dest  = '0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        do_op(8'd3, 8'd5, 3'd2);
        drain();
        do_op(8'hFF, 8'hFF, 3'd7);
        drain();
        do_op(8'h00, 8'hAB, 3'd4);
        drain();

        // A second start during CALC must be ignored.
        do_op(8'd3, 8'd5, 3'd1);
        repeat (2) @(negedge clk);
        do_op(8'd9, 8'd9, 3'd6);
        drain();

        // Abort mid-CALC: outputs clear at once and no write follows.
        do_op(8'h10, 8'h10, 3'd3);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        free_edge = 0;
        ovf_exp   = 1'b0;
        ovf_edge  = -1;
        last_addr = '0;
        last_data = '0;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        do_op(8'd2, 8'd2, 3'd3);
        drain();

        // Start held high: only IDLE cycles accept, operands change every cycle.
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start = 1'b1;
            opA   = 8'($urandom);
            opB   = 8'($urandom);
            dest  = 3'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        // Random sparse requests.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            opA   = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            opB   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            dest  = 3'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
